// File: rtl/tx_frame_ctrl_if.sv
// tx_frame_ctrl_if: host, frame buffer and serializer signals of the TX frame controller
interface tx_frame_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int RETRY_W = 4
);
  logic               start;
  logic [ADDR_W-1:0]  frame_len;
  logic [RETRY_W-1:0] max_retry;
  logic               send_break;
  logic               cancel;
  logic               busy;
  logic               done;
  logic               fail;
  logic               brk_done;
  logic [RETRY_W-1:0] retry_cnt;
  logic [ADDR_W-1:0]  rd_addr;
  logic [7:0]         rd_data;
  logic [7:0]         data;
  logic               has_data;
  logic               ack_data;
  logic               is_crc_byte;
  logic               is_last_byte;
  logic [15:0]        crc_data;
  logic               has_break;
  logic               ack_break;
  logic               cd;
  logic               err;
  logic               abort;

  modport master (
    input  start, frame_len, max_retry, send_break, cancel, rd_data, ack_data, crc_data, ack_break, cd, err,
    output busy, done, fail, brk_done, retry_cnt, rd_addr, data, has_data, is_crc_byte, is_last_byte,
           has_break, abort
  );

  modport slave (
    output start, frame_len, max_retry, send_break, cancel, rd_data, ack_data, crc_data, ack_break, cd, err,
    input  busy, done, fail, brk_done, retry_cnt, rd_addr, data, has_data, is_crc_byte, is_last_byte,
           has_break, abort
  );
endinterface

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: feeds one buffered frame plus its trailing CRC to the serializer, with retry, break and cancel
module tx_frame_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int RETRY_W = 4
) (
  input logic            clk,
  input logic            reset,
  tx_frame_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CRC_L, CRC_H, BREAK} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ph_q, ph_d;
  logic [ADDR_W-1:0]  idx_q, idx_d, len_q, len_d, rd_addr_q, rd_addr_d;
  logic [RETRY_W-1:0] maxr_q, maxr_d, rc_q, rc_d;
  logic [15:0]        crc_q, crc_d;
  logic [7:0]         data_q, data_d;
  logic               has_data_q, has_data_d, is_crc_q, is_crc_d, is_last_q, is_last_d;
  logic               has_break_q, has_break_d, busy_q, busy_d, done_q, done_d;
  logic               fail_q, fail_d, brk_done_q, brk_done_d, abort_q, abort_d;
  logic               in_frame;

  assign in_frame         = state_q inside {FETCH, SEND, CRC_L, CRC_H};
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.brk_done     = brk_done_q;
  assign bus.retry_cnt    = rc_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.data         = data_q;
  assign bus.has_data     = has_data_q;
  assign bus.is_crc_byte  = is_crc_q;
  assign bus.is_last_byte = is_last_q;
  assign bus.has_break    = has_break_q;
  assign bus.abort        = abort_q;

  // next state: cancel beats collision/error, which beat the per-state handshakes
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    len_d       = len_q;
    maxr_d      = maxr_q;
    rc_d        = rc_q;
    crc_d       = crc_q;
    rd_addr_d   = rd_addr_q;
    data_d      = data_q;
    has_data_d  = has_data_q;
    is_crc_d    = is_crc_q;
    is_last_d   = is_last_q;
    has_break_d = has_break_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    brk_done_d  = 1'b0;
    abort_d     = 1'b0;
    if (state_q != IDLE && bus.cancel) begin
      abort_d     = 1'b1;
      fail_d      = 1'b1;
      busy_d      = 1'b0;
      has_data_d  = 1'b0;
      has_break_d = 1'b0;
      is_crc_d    = 1'b0;
      is_last_d   = 1'b0;
      state_d     = IDLE;
    end else if (in_frame && (bus.cd || bus.err)) begin
      has_data_d = 1'b0;
      is_crc_d   = 1'b0;
      is_last_d  = 1'b0;
      if (!bus.err && rc_q < maxr_q) begin
        rc_d    = rc_q + RETRY_W'(1);
        idx_d   = '0;
        ph_d    = '0;
        state_d = FETCH;
      end else begin
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.send_break) begin
            has_break_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = BREAK;
          end else if (bus.start && bus.frame_len == '0) begin
            fail_d = 1'b1;
          end else if (bus.start) begin
            len_d   = bus.frame_len;
            maxr_d  = bus.max_retry;
            rc_d    = '0;
            idx_d   = '0;
            ph_d    = '0;
            busy_d  = 1'b1;
            state_d = FETCH;
          end
        end
        FETCH: begin
          rd_addr_d = (ph_q == 2'd0) ? idx_q : rd_addr_q;
          ph_d      = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
          if (ph_q == 2'd2) begin
            data_d     = bus.rd_data;
            has_data_d = 1'b1;
            state_d    = SEND;
          end
        end
        SEND: begin
          if (bus.ack_data) begin
            has_data_d = 1'b0;
            if (idx_q == len_q - ADDR_W'(1)) begin
              crc_d   = bus.crc_data;
              state_d = CRC_L;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              ph_d    = '0;
              state_d = FETCH;
            end
          end
        end
        CRC_L: begin
          if (!has_data_q) begin
            data_d     = crc_q[7:0];
            is_crc_d   = 1'b1;
            has_data_d = 1'b1;
          end else if (bus.ack_data) begin
            data_d    = crc_q[15:8];
            is_last_d = 1'b1;
            state_d   = CRC_H;
          end
        end
        CRC_H: begin
          if (bus.ack_data) begin
            has_data_d = 1'b0;
            is_crc_d   = 1'b0;
            is_last_d  = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
        BREAK: begin
          if (bus.ack_break) begin
            has_break_d = 1'b0;
            brk_done_d  = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and registered outputs; reset drops any frame silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      maxr_q      <= '0;
      rc_q        <= '0;
      crc_q       <= '0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      has_data_q  <= 1'b0;
      is_crc_q    <= 1'b0;
      is_last_q   <= 1'b0;
      has_break_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      brk_done_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      maxr_q      <= maxr_d;
      rc_q        <= rc_d;
      crc_q       <= crc_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      has_data_q  <= has_data_d;
      is_crc_q    <= is_crc_d;
      is_last_q   <= is_last_d;
      has_break_q <= has_break_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      brk_done_q  <= brk_done_d;
      abort_q     <= abort_d;
    end
  end
endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: scoreboard bench with a frame-level reference model and a randomized serializer
module tb_tx_frame_ctrl;
  localparam int AW = 8;
  localparam int RW = 4;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  int          model_rc = 0;
  int          ev_kind [4];
  int          ev_pos [4];
  logic [7:0]  mem [256];
  logic [9:0]  exp_b [$];
  logic [10:0] exp_e [$];
  logic [9:0]  eb;
  logic [10:0] ee, ae;
  logic [28:0] outs;

  tx_frame_ctrl_if #(.ADDR_W(AW), .RETRY_W(RW)) bus ();
  tx_frame_ctrl #(.ADDR_W(AW), .RETRY_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  assign outs = {bus.busy, bus.done, bus.fail, bus.brk_done, bus.retry_cnt, bus.rd_addr, bus.data,
                 bus.has_data, bus.is_crc_byte, bus.is_last_byte, bus.has_break, bus.abort};

  always #5 clk = ~clk;

  // synchronous-read frame buffer
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  // monitor: every consumed byte and every outcome pulse is checked against the scoreboard
  always @(negedge clk) begin
    if (!reset && bus.has_data && bus.ack_data && !bus.cd && !bus.err && !bus.cancel) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL byte: got %h crc=%b last=%b, required no byte", bus.data, bus.is_crc_byte, bus.is_last_byte);
      end else begin
        eb = exp_b.pop_front();
        if ({bus.data, bus.is_crc_byte, bus.is_last_byte} !== eb) begin
          errors++;
          $display("FAIL byte: got %h crc=%b last=%b, required %h crc=%b last=%b",
                   bus.data, bus.is_crc_byte, bus.is_last_byte, eb[9:2], eb[1], eb[0]);
        end
      end
    end
    if (!reset && (bus.done || bus.fail || bus.brk_done)) begin
      checks++;
      ae = {bus.done, bus.fail, bus.brk_done, bus.abort, bus.retry_cnt, bus.busy, bus.has_data, bus.has_break};
      if (exp_e.size() == 0) begin
        errors++;
        $display("FAIL outcome: got done/fail/brk/abort/retry/busy/hd/hb=%b, required no outcome", ae);
      end else begin
        ee = exp_e.pop_front();
        if (ae !== ee) begin
          errors++;
          $display("FAIL outcome: got done/fail/brk/abort/retry/busy/hd/hb=%b, required %b", ae, ee);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hd(output int n);
    n = 0;
    while (!bus.has_data && n < 30) begin
      cyc();
      n++;
    end
    if (!bus.has_data) begin
      checks++;
      errors++;
      $display("FAIL has_data_timeout: has_data=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      cyc();
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic set_ev(input int k0, input int p0, input int k1, input int p1);
    ev_kind = '{k0, k1, 0, 0};
    ev_pos  = '{p0, p1, 0, 0};
  endtask

  // reference: stream = payload then CRC low/high; each attempt sends a prefix until its event
  task automatic model_frame(input int len, input logic [15:0] crc, input int maxr, output int n_att);
    logic [9:0] s [$];
    int rc = 0;
    int stop;
    for (int i = 0; i < len; i++) s.push_back({mem[i], 2'b00});
    s.push_back({crc[7:0], 2'b10});
    s.push_back({crc[15:8], 2'b11});
    n_att = 0;
    for (int a = 0; a < 4; a++) begin
      n_att++;
      stop = (ev_kind[a] == 0) ? len + 2 : ev_pos[a];
      for (int i = 0; i < stop; i++) exp_b.push_back(s[i]);
      if (ev_kind[a] == 0) begin
        exp_e.push_back({4'b1000, 4'(rc), 3'b000});
        break;
      end
      if (ev_kind[a] == 1 && rc < maxr) begin
        rc++;
        continue;
      end
      exp_e.push_back({3'b010, 1'(ev_kind[a] == 3), 4'(rc), 3'b000});
      break;
    end
    model_rc = rc;
  endtask

  // kinds: 0 none, 1 cd (ack maybe), 2 err+cd, 3 cancel+ack
  task automatic drive_frame(input int len, input logic [15:0] crc, input int maxr);
    int n_att, n, lat;
    model_frame(len, crc, maxr, n_att);
    bus.frame_len = AW'(len);
    bus.max_retry = RW'(maxr);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    lat = 0;
    if ($urandom_range(0, 1) == 1) begin
      bus.start = 1'b1;
      bus.send_break = 1'b1;
      bus.frame_len = AW'(len + 1);
      cyc();
      bus.start = 1'b0;
      bus.send_break = 1'b0;
      lat = 1;
    end
    for (int a = 0; a < n_att; a++) begin
      for (int p = 0; p < len + 2; p++) begin
        wait_hd(n);
        if (a == 0 && p == 0) begin
          checks++;
          if (lat + n != 3) begin
            errors++;
            $display("FAIL start_latency: has_data rose %0d cycles after start edge, required 3", lat + n);
          end
        end
        repeat ($urandom_range(0, 2)) cyc();
        if (ev_kind[a] != 0 && ev_pos[a] == p) begin
          bus.cd = ev_kind[a] != 3;
          bus.err = ev_kind[a] == 2;
          bus.cancel = ev_kind[a] == 3;
          bus.ack_data = ev_kind[a] == 3 || $urandom_range(0, 1) == 1;
          bus.crc_data = 16'($urandom);
          cyc();
          bus.cd = 1'b0;
          bus.err = 1'b0;
          bus.cancel = 1'b0;
          bus.ack_data = 1'b0;
          break;
        end
        bus.crc_data = (p == len - 1) ? crc : 16'($urandom);
        bus.ack_data = 1'b1;
        cyc();
        bus.ack_data = 1'b0;
        bus.crc_data = 16'($urandom);
      end
    end
    wait_idle();
  endtask

  task automatic drive_break(input bit with_start);
    int n = 0;
    exp_e.push_back({4'b0010, 4'(model_rc), 3'b000});
    bus.send_break = 1'b1;
    bus.start = with_start;
    bus.frame_len = 8'd3;
    bus.max_retry = '0;
    cyc();
    bus.send_break = 1'b0;
    bus.start = 1'b0;
    while (!bus.has_break && n < 10) begin
      cyc();
      n++;
    end
    if (!bus.has_break) begin
      checks++;
      errors++;
      $display("FAIL has_break_timeout: has_break=0, required 1");
    end
    bus.cd = 1'b1;
    bus.err = 1'b1;
    cyc();
    bus.cd = 1'b0;
    bus.err = 1'b0;
    repeat ($urandom_range(0, 2)) cyc();
    bus.ack_break = 1'b1;
    cyc();
    bus.ack_break = 1'b0;
    wait_idle();
  endtask

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int n, len, r;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.start = 1'b0;
    bus.frame_len = '0;
    bus.max_retry = '0;
    bus.send_break = 1'b0;
    bus.cancel = 1'b0;
    bus.ack_data = 1'b0;
    bus.crc_data = '0;
    bus.ack_break = 1'b0;
    bus.cd = 1'b0;
    bus.err = 1'b0;
    reset = 1'b1;
    repeat (2) cyc();
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%h, required 0", outs);
    end
    reset = 1'b0;
    cyc();

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    set_ev(0, 0, 0, 0);
    drive_frame(3, 16'hBEEF, 0);
    set_ev(1, 1, 0, 0);
    drive_frame(3, 16'hBEEF, 2);
    set_ev(1, 2, 1, 1);
    drive_frame(3, 16'h1234, 1);
    set_ev(2, 3, 0, 0);
    drive_frame(3, 16'h5A5A, 3);
    set_ev(3, 1, 0, 0);
    drive_frame(3, 16'h0F0F, 0);
    set_ev(0, 0, 0, 0);
    drive_frame(2, 16'hC001, 1);
    drive_break(1'b1);
    exp_e.push_back({4'b0100, 4'(model_rc), 3'b000});
    bus.frame_len = '0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) drive_break(1'($urandom_range(0, 1)));
      len = $urandom_range(1, 6);
      fill(len);
      for (int a = 0; a < 4; a++) begin
        r = $urandom_range(0, 99);
        ev_kind[a] = r < 40 ? 1 : r < 46 ? 2 : r < 52 ? 3 : 0;
        ev_pos[a] = $urandom_range(0, len + 1);
      end
      drive_frame(len, 16'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        bus.cancel = 1'b1;
        cyc();
        bus.cancel = 1'b0;
      end
      repeat ($urandom_range(0, 2)) cyc();
    end

    fill(5);
    bus.frame_len = 8'd5;
    bus.max_retry = '0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    wait_hd(n);
    cyc();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs=%h, required 0", outs);
    end
    repeat (2) cyc();
    reset = 1'b0;
    model_rc = 0;
    cyc();
    set_ev(0, 0, 0, 0);
    drive_frame(4, 16'hA55A, 0);

    repeat (4) cyc();
    checks++;
    if (exp_b.size() != 0 || exp_e.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d bytes and %0d outcomes still expected, required 0", exp_b.size(), exp_e.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
